// File: rtl/typed_word_serializer_if.sv
// Stream bundle for typed_word_serializer: typed input handshake and narrow beat output.
// The beat index width is derived from WIDTH and IN_t exactly as in the serializer.
interface typed_word_serializer_if #(
  parameter int  WIDTH = 10,
  parameter type IN_t  = logic [31:0]
);
  localparam int TW    = $bits(IN_t);
  localparam int BEATS = (TW + WIDTH - 1) / WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             in_valid;
  logic             in_ready;
  IN_t              in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CW-1:0]    out_beat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_beat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_beat
  );
endinterface

// File: rtl/typed_word_serializer.sv
// Splits one IN_t value per input handshake into BEATS WIDTH-bit beats with a last flag.
// Back-to-back values stream without a bubble: the next value is taken on the last-beat handshake.
module typed_word_serializer #(
  parameter int  WIDTH     = 10,
  parameter type IN_t      = logic [31:0],
  parameter bit  LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  typed_word_serializer_if.slave bus
);
  localparam int TW    = $bits(IN_t);
  localparam int BEATS = (TW + WIDTH - 1) / WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = BEATS * WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic          ONE_BEAT  = (BEATS == 1) ? 1'b1 : 1'b0;

  if (WIDTH < 1) begin : g_bad_width
    $error("typed_word_serializer: WIDTH must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat idx of the zero-padded word; MSB-first order walks the slices from the top.
  function automatic logic [WIDTH-1:0] beat_slice(input logic [PW-1:0] word,
                                                  input logic [CW-1:0] idx);
    logic [PW-1:0] shifted;
    int unsigned   pos;
    if (LSB_FIRST) begin
      pos = 32'(idx);
    end else begin
      pos = 32'(LAST_BEAT) - 32'(idx);
    end
    shifted = word >> (pos * 32'(WIDTH));
    return shifted[WIDTH-1:0];
  endfunction

  state_t           state_r;
  logic [PW-1:0]    hold_r;
  logic [CW-1:0]    beat_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [WIDTH-1:0] out_data_r;

  logic [TW-1:0]    in_flat_s;
  logic [PW-1:0]    in_padded_s;
  logic [CW-1:0]    next_beat_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;

  assign in_flat_s   = bus.in_data;
  assign in_padded_s = PW'(in_flat_s);
  assign next_beat_s = beat_r + CW'(1);
  // Ready through out_ready on the last beat keeps back-to-back values bubble-free.
  assign in_ready_s  = (state_r == IDLE) | (out_last_r & bus.out_ready);
  assign in_fire_s   = bus.in_valid & in_ready_s;
  assign out_fire_s  = out_valid_r & bus.out_ready;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_beat  = beat_r;

  // Control FSM, capture register and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hold_r      <= '0;
      beat_r      <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_fire_s) begin
            hold_r      <= in_padded_s;
            beat_r      <= '0;
            out_data_r  <= beat_slice(in_padded_s, CW'(0));
            out_last_r  <= ONE_BEAT;
            out_valid_r <= 1'b1;
            state_r     <= SEND;
          end
        end
        SEND: begin
          if (out_fire_s) begin
            if (out_last_r) begin
              if (in_fire_s) begin
                hold_r      <= in_padded_s;
                beat_r      <= '0;
                out_data_r  <= beat_slice(in_padded_s, CW'(0));
                out_last_r  <= ONE_BEAT;
                out_valid_r <= 1'b1;
                state_r     <= SEND;
              end else begin
                beat_r      <= '0;
                out_data_r  <= '0;
                out_last_r  <= 1'b0;
                out_valid_r <= 1'b0;
                state_r     <= IDLE;
              end
            end else begin
              beat_r     <= next_beat_s;
              out_data_r <= beat_slice(hold_r, next_beat_s);
              out_last_r <= (next_beat_s == LAST_BEAT);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          beat_r      <= '0;
          out_data_r  <= '0;
          out_last_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
